// File: rtl/memory_subsystem.sv
// Memory datapath stage: MAR/MDR registers plus a word-addressed RAM with
// parameterised read/write latency, edge-triggered requests and a completion pulse.
module memory_subsystem #(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MAR_enable,
  input  logic                  MDR_enable,
  input  logic                  MDR_read,
  input  logic                  RAM_write,
  input  logic                  Preload_we,
  input  logic [ADDR_WIDTH-1:0] Preload_addr,
  input  logic [DATA_WIDTH-1:0] Preload_data,
  output logic [DATA_WIDTH-1:0] MDR_data,
  output logic [ADDR_WIDTH-1:0] MAR_q,
  output logic                  Mem_ready,
  output logic                  Busy,
  output logic                  Overlap_err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  // Counter holds remaining wait edges; latency 1 means complete on the next edge.
  localparam logic [2:0] RdLoad = 3'(READ_LATENCY - 1);
  localparam logic [2:0] WrLoad = 3'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWrWait
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mar_addr_q, mar_addr_d;
  logic [DATA_WIDTH-1:0]   mdr_word_q, mdr_word_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    rd_lvl_q, wr_lvl_q;
  logic                    ready_q, ready_d;
  logic                    overlap_q, overlap_d;

  logic                    rd_lvl, rd_req, wr_req, bus_load;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [DATA_WIDTH-1:0]   mem [Depth];

  assign rd_lvl   = MDR_enable & MDR_read;
  assign rd_req   = rd_lvl & ~rd_lvl_q;
  assign wr_req   = RAM_write & ~wr_lvl_q;
  assign bus_load = MDR_enable & ~MDR_read;

  always_comb begin
    state_d    = state_q;
    mar_addr_d = MAR_enable ? BusMuxOut[ADDR_WIDTH-1:0] : mar_addr_q;
    mdr_word_d = mdr_word_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    overlap_d  = overlap_q;
    mem_we     = 1'b0;
    mem_waddr  = Preload_addr;
    mem_wdata  = Preload_data;

    unique case (state_q)
      StIdle: begin
        if (bus_load) mdr_word_d = BusMuxOut;
        // Requests use the MAR value from before this edge.
        if (wr_req) begin
          addr_d  = mar_addr_q;
          data_d  = mdr_word_q;
          cnt_d   = WrLoad;
          state_d = StWrWait;
          if (rd_req) overlap_d = 1'b1;
        end else if (rd_req) begin
          addr_d  = mar_addr_q;
          cnt_d   = RdLoad;
          state_d = StRdWait;
        end else if (Preload_we) begin
          mem_we = 1'b1;
        end
      end

      StRdWait: begin
        if (rd_req || wr_req || bus_load) overlap_d = 1'b1;
        if (cnt_q == 3'd0) begin
          mdr_word_d = mem[addr_q];
          ready_d    = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      StWrWait: begin
        if (rd_req || wr_req || bus_load) overlap_d = 1'b1;
        if (cnt_q == 3'd0) begin
          mem_we    = 1'b1;
          mem_waddr = addr_q;
          mem_wdata = data_q;
          ready_d   = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      mar_addr_q <= '0;
      mdr_word_q <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_lvl_q   <= 1'b0;
      wr_lvl_q   <= 1'b0;
      ready_q    <= 1'b0;
      overlap_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mar_addr_q <= mar_addr_d;
      mdr_word_q <= mdr_word_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_lvl_q   <= rd_lvl;
      wr_lvl_q   <= RAM_write;
      ready_q    <= ready_d;
      overlap_q  <= overlap_d;
    end
  end

  // RAM keeps its contents across Reset; writes are blocked while Reset is high.
  always_ff @(posedge Clock) begin
    if (mem_we && !Reset) mem[mem_waddr] <= mem_wdata;
  end

  assign MDR_data    = mdr_word_q;
  assign MAR_q       = mar_addr_q;
  assign Mem_ready   = ready_q;
  assign Busy        = (state_q != StIdle);
  assign Overlap_err = overlap_q;

endmodule

// File: tb/tb_memory_subsystem.sv
// Directed bench for memory_subsystem with READ_LATENCY=3, WRITE_LATENCY=2.
module tb_memory_subsystem;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned RL = 3;
  localparam int unsigned WL = 2;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [DW-1:0] BusMuxOut;
  logic          MAR_enable, MDR_enable, MDR_read, RAM_write, Preload_we;
  logic [AW-1:0] Preload_addr;
  logic [DW-1:0] Preload_data;
  logic [DW-1:0] MDR_data;
  logic [AW-1:0] MAR_q;
  logic          Mem_ready, Busy, Overlap_err;

  int total = 0;
  int bad   = 0;
  int pulses;

  memory_subsystem #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .BusMuxOut   (BusMuxOut),
    .MAR_enable  (MAR_enable),
    .MDR_enable  (MDR_enable),
    .MDR_read    (MDR_read),
    .RAM_write   (RAM_write),
    .Preload_we  (Preload_we),
    .Preload_addr(Preload_addr),
    .Preload_data(Preload_data),
    .MDR_data    (MDR_data),
    .MAR_q       (MAR_q),
    .Mem_ready   (Mem_ready),
    .Busy        (Busy),
    .Overlap_err (Overlap_err)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    Preload_we   = 1'b1;
    Preload_addr = a;
    Preload_data = d;
    tick();
    Preload_we   = 1'b0;
  endtask

  task automatic load_mar(input logic [DW-1:0] v);
    BusMuxOut  = v;
    MAR_enable = 1'b1;
    tick();
    MAR_enable = 1'b0;
  endtask

  task automatic load_mdr(input logic [DW-1:0] v);
    BusMuxOut  = v;
    MDR_enable = 1'b1;
    MDR_read   = 1'b0;
    tick();
    MDR_enable = 1'b0;
  endtask

  task automatic read_pulse();
    MDR_enable = 1'b1;
    MDR_read   = 1'b1;
    tick();
    MDR_enable = 1'b0;
    MDR_read   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    load_mar({23'd0, a});
    read_pulse();
    repeat (RL) tick();
    check(tag, MDR_data, exp);
    check({tag, "_rdy"}, {31'd0, Mem_ready}, 32'd1);
  endtask

  initial begin
    Reset = 1'b1;
    BusMuxOut = '0; MAR_enable = 0; MDR_enable = 0; MDR_read = 0; RAM_write = 0;
    Preload_we = 0; Preload_addr = '0; Preload_data = '0;
    #12;
    check("rst_mdr", MDR_data, 32'd0);
    check("rst_mar", {23'd0, MAR_q}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_rdy", {31'd0, Mem_ready}, 32'd0);
    check("rst_ovl", {31'd0, Overlap_err}, 32'd0);
    Reset = 1'b0;
    tick();

    // Read latency
    preload(9'h10, 32'h12345678);
    load_mar(32'h10);
    read_pulse();
    check("lat_busy0", {31'd0, Busy}, 32'd1);
    check("lat_rdy0", {31'd0, Mem_ready}, 32'd0);
    check("lat_mdr0", MDR_data, 32'd0);
    tick();
    check("lat_busy1", {31'd0, Busy}, 32'd1);
    check("lat_rdy1", {31'd0, Mem_ready}, 32'd0);
    tick();
    check("lat_busy2", {31'd0, Busy}, 32'd1);
    check("lat_mdr2", MDR_data, 32'd0);
    tick();
    check("lat_mdr3", MDR_data, 32'h12345678);
    check("lat_rdy3", {31'd0, Mem_ready}, 32'd1);
    check("lat_busy3", {31'd0, Busy}, 32'd0);
    tick();
    check("lat_rdy4", {31'd0, Mem_ready}, 32'd0);

    // Reset mid-read
    preload(9'h5, 32'hDEADBEEF);
    load_mar(32'h5);
    read_pulse();
    tick();
    Reset = 1'b1;
    #2;
    check("rmid_mdr", MDR_data, 32'd0);
    check("rmid_busy", {31'd0, Busy}, 32'd0);
    check("rmid_mar", {23'd0, MAR_q}, 32'd0);
    Reset = 1'b0;
    pulses = 0;
    repeat (5) begin
      tick();
      pulses += int'(Mem_ready);
    end
    check("rmid_nopulse", pulses, 32'd0);
    check("rmid_mdr_after", MDR_data, 32'd0);
    read_check("rmid_reread", 9'h5, 32'hDEADBEEF);

    // Store with RAM_write held high
    load_mar(32'h20);
    load_mdr(32'hCAFEF00D);
    check("st_mdr_bus", MDR_data, 32'hCAFEF00D);
    RAM_write = 1'b1;
    pulses = 0;
    repeat (10) begin
      tick();
      pulses += int'(Mem_ready);
    end
    RAM_write = 1'b0;
    check("st_one_pulse", pulses, 32'd1);
    check("st_busy", {31'd0, Busy}, 32'd0);
    check("st_ovl", {31'd0, Overlap_err}, 32'd0);
    load_mdr(32'd0);
    read_check("st_readback", 9'h20, 32'hCAFEF00D);

    // Address capture
    preload(9'h3, 32'h1);
    preload(9'h4, 32'h2);
    load_mar(32'h3);
    read_pulse();
    load_mar(32'h4);
    repeat (RL - 1) tick();
    check("cap_mdr", MDR_data, 32'h1);
    check("cap_rdy", {31'd0, Mem_ready}, 32'd1);
    check("cap_mar", {23'd0, MAR_q}, 32'h4);

    // MAR load and request on the same edge: request uses old MAR (4)
    BusMuxOut  = 32'h3;
    MAR_enable = 1'b1;
    MDR_enable = 1'b1;
    MDR_read   = 1'b1;
    tick();
    MAR_enable = 1'b0; MDR_enable = 1'b0; MDR_read = 1'b0;
    repeat (RL) tick();
    check("old_mar_mdr", MDR_data, 32'h2);
    check("old_mar_q", {23'd0, MAR_q}, 32'h3);

    // Requests and preload while busy are dropped
    preload(9'h9, 32'h11);
    load_mar(32'h7);
    load_mdr(32'hAAAA5555);
    RAM_write = 1'b1;
    tick();
    RAM_write = 1'b0;
    check("bd_busy", {31'd0, Busy}, 32'd1);
    MDR_enable = 1'b1; MDR_read = 1'b1;
    Preload_we = 1'b1; Preload_addr = 9'h9; Preload_data = 32'h99;
    tick();
    MDR_enable = 1'b0; MDR_read = 1'b0; Preload_we = 1'b0;
    check("bd_ovl", {31'd0, Overlap_err}, 32'd1);
    check("bd_rdy_early", {31'd0, Mem_ready}, 32'd0);
    tick();
    check("bd_rdy", {31'd0, Mem_ready}, 32'd1);
    check("bd_mdr", MDR_data, 32'hAAAA5555);
    check("bd_busy_done", {31'd0, Busy}, 32'd0);
    read_check("bd_preload_ign", 9'h9, 32'h11);
    read_check("bd_wr_data", 9'h7, 32'hAAAA5555);

    Reset = 1'b1;
    #2;
    check("ovl_rst_clr", {31'd0, Overlap_err}, 32'd0);
    Reset = 1'b0;
    tick();

    // Write/read collision on the same edge
    preload(9'h30, 32'h1111);
    load_mar(32'h30);
    load_mdr(32'h3030);
    RAM_write = 1'b1; MDR_enable = 1'b1; MDR_read = 1'b1;
    tick();
    RAM_write = 1'b0; MDR_enable = 1'b0; MDR_read = 1'b0;
    check("col_ovl", {31'd0, Overlap_err}, 32'd1);
    check("col_busy", {31'd0, Busy}, 32'd1);
    repeat (WL) tick();
    check("col_rdy", {31'd0, Mem_ready}, 32'd1);
    check("col_mdr", MDR_data, 32'h3030);
    pulses = 0;
    repeat (6) begin
      tick();
      pulses += int'(Mem_ready);
    end
    check("col_no_read", pulses, 32'd0);
    check("col_idle", {31'd0, Busy}, 32'd0);
    load_mdr(32'd0);
    read_check("col_wr_data", 9'h30, 32'h3030);
    check("col_ovl_sticky", {31'd0, Overlap_err}, 32'd1);
    Reset = 1'b1;
    #2;
    check("col_ovl_rst", {31'd0, Overlap_err}, 32'd0);
    Reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
